mips_bus_mem_responder: RTL and testbench

Memory-side responder for the CPU's Avalon-style bus: it answers the read/write requests issued by `mips_cpu_bus`. Holds a word-organised RAM and inserts a configurable number of wait states per transfer. Honours byte enables and flags protocol violations. Used as the memory model in bus-level testbenches and as the template for the on-chip RAM.

---
 rtl/mips_bus_mem_responder_if.sv | 26 ++
 rtl/mips_bus_mem_responder.sv | 156 +++++++++++++++
 tb/tb_mips_bus_mem_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_mem_responder_if
// Description : Avalon-style CPU memory bus between mips_cpu_bus and the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_bus_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/mips_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_mem_responder
// Description : Word RAM answering CPU bus requests with programmable wait
//               states, byte-lane writes and sticky protocol-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_mem_responder #(
    parameter int    DEPTH_LOG2  = 10,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_bus_mem_responder_if.slave bus,
    output logic                    error,
    output logic [31:0]             xfer_count
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    localparam logic       c_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic       c_ONE_WAIT  = (WAIT_CYCLES == 1);
    // The IDLE cycle that first sees the request already counts as one wait
    // cycle, so WAIT runs for WAIT_CYCLES-1 cycles (cnt counts down to 0).
    localparam logic [3:0] c_CNT_LOAD  = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    logic [31:0] r_mem [0:(2**DEPTH_LOG2)-1];

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_mis;
    logic        r_error;
    logic [31:0] r_xfer_count;

    logic                  w_req;
    logic                  w_both;
    logic                  w_mis_in;
    logic                  w_changed;
    logic                  w_zw_fire;
    logic                  w_fire;
    logic                  w_in_ack;
    logic                  w_c_read;
    logic                  w_c_write;
    logic                  w_c_mis;
    logic [31:0]           w_c_wdata;
    logic [3:0]            w_c_be;
    logic [DEPTH_LOG2-1:0] w_c_idx;
    logic                  w_mem_we;

    assign w_req    = bus.read | bus.write;
    assign w_both   = bus.read & bus.write;
    assign w_mis_in = (bus.address[1:0] != 2'b00);
    assign w_in_ack = (r_state == c_ST_ACK);

    assign w_changed = (bus.address != r_addr) || (bus.read != r_read) ||
                       (bus.write != r_write) || (bus.writedata != r_wdata) ||
                       (bus.byteenable != r_be);

    // Zero-wait configuration completes straight out of IDLE from live inputs.
    assign w_zw_fire = c_ZERO_WAIT && (r_state == c_ST_IDLE) && w_req && !w_both;
    assign w_fire    = !reset && (w_zw_fire || w_in_ack);

    assign w_c_read  = w_in_ack ? r_read  : bus.read;
    assign w_c_write = w_in_ack ? r_write : bus.write;
    assign w_c_mis   = w_in_ack ? r_mis   : w_mis_in;
    assign w_c_wdata = w_in_ack ? r_wdata : bus.writedata;
    assign w_c_be    = w_in_ack ? r_be    : bus.byteenable;
    assign w_c_idx   = w_in_ack ? r_addr[DEPTH_LOG2+1:2] : bus.address[DEPTH_LOG2+1:2];

    assign w_mem_we = w_fire && w_c_write && !w_c_mis;

    assign bus.waitrequest = w_req && !reset && !w_in_ack &&
                             !((r_state == c_ST_IDLE) && (c_ZERO_WAIT || w_both));
    assign bus.readdata    = (w_fire && w_c_read && !w_c_mis) ? r_mem[w_c_idx] : 32'd0;

    assign error      = r_error;
    assign xfer_count = r_xfer_count;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_be[b]) begin
                    r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 32'd0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_mis        <= 1'b0;
            r_error      <= 1'b0;
            r_xfer_count <= 32'd0;
        end else begin
            if (w_fire && !w_c_mis) begin
                r_xfer_count <= r_xfer_count + 32'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req && (w_both || w_mis_in)) begin
                        r_error <= 1'b1;
                    end
                    if (w_req && !w_both && !c_ZERO_WAIT) begin
                        r_addr  <= bus.address;
                        r_read  <= bus.read;
                        r_write <= bus.write;
                        r_wdata <= bus.writedata;
                        r_be    <= bus.byteenable;
                        r_mis   <= w_mis_in;
                        if (c_ONE_WAIT) begin
                            r_state <= c_ST_ACK;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                end
                c_ST_WAIT: begin
                    // Master must hold the request untouched while stalled.
                    if (w_changed) begin
                        r_error <= 1'b1;
                        r_state <= c_ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= c_ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_ACK: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_mem_responder
// Description : Directed bench for the memory responder (2-wait and 0-wait).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        error2, error0;
    logic [31:0] count2, count0;
    int          vectors = 0;
    int          fails   = 0;

    mips_bus_mem_responder_if bus2 ();
    mips_bus_mem_responder_if bus0 ();

    mips_bus_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave), .error(error2), .xfer_count(count2)
    );

    mips_bus_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .error(error0), .xfer_count(count0)
    );

    always #5 clk = ~clk;

    task automatic set_req(input bit sel, input logic [31:0] addr, input bit rd, input bit wr,
                           input logic [31:0] data, input logic [3:0] be);
        if (sel) begin
            bus0.address = addr; bus0.read = rd; bus0.write = wr;
            bus0.writedata = data; bus0.byteenable = be;
        end else begin
            bus2.address = addr; bus2.read = rd; bus2.write = wr;
            bus2.writedata = data; bus2.byteenable = be;
        end
    endtask

    function automatic logic get_wait(input bit sel);
        return sel ? bus0.waitrequest : bus2.waitrequest;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus0.readdata : bus2.readdata;
    endfunction

    // Enters and leaves one time unit after a rising edge.
    task automatic bus_xfer(input bit sel, input logic [31:0] addr, input bit rd, input bit wr,
                            input logic [31:0] data, input logic [3:0] be,
                            output int waits, output logic [31:0] rdata);
        waits = 0;
        rdata = 32'hxxxx_xxxx;
        set_req(sel, addr, rd, wr, data, be);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!get_wait(sel)) begin
                rdata = get_rdata(sel);
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        set_req(sel, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        set_req(1, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        @(posedge clk); #1;
        set_req(0, 32'd0, 1'b1, 1'b0, 32'd0, 4'hF);
        #1;
        vectors++; if (bus2.waitrequest !== 1'b0) begin fails++; $display("FAIL reset_wait got=%b exp=0", bus2.waitrequest); end
        vectors++; if (bus2.readdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", bus2.readdata); end
        vectors++; if (error2 !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error2); end
        vectors++; if (count2 !== 32'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count2); end
        @(posedge clk); #1;
        set_req(0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        reset = 1'b0;
    endtask

    task automatic test_boot_read();
        int w; logic [31:0] d;
        bus_xfer(0, 32'h0000_0000, 1'b0, 1'b1, 32'h8C62_0000, 4'hF, w, d);
        vectors++; if (w !== 2) begin fails++; $display("FAIL boot_write_waits got=%0d exp=2", w); end
        bus_xfer(0, 32'hBFC0_0000, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (w !== 2) begin fails++; $display("FAIL boot_read_waits got=%0d exp=2", w); end
        vectors++; if (d !== 32'h8C62_0000) begin fails++; $display("FAIL boot_read_data got=%h exp=8c620000", d); end
        vectors++; if (count2 !== 32'd2) begin fails++; $display("FAIL boot_count got=%0d exp=2", count2); end
    endtask

    task automatic test_write_read();
        int w; logic [31:0] d;
        bus_xfer(0, 32'd100, 1'b0, 1'b1, 32'h0000_0009, 4'hF, w, d);
        vectors++; if (w !== 2) begin fails++; $display("FAIL wr100_waits got=%0d exp=2", w); end
        bus_xfer(0, 32'd100, 1'b1, 1'b0, 32'd0, 4'h0, w, d);
        vectors++; if (d !== 32'h0000_0009) begin fails++; $display("FAIL rd100_data got=%h exp=00000009", d); end
        vectors++; if (count2 !== 32'd4) begin fails++; $display("FAIL wr_rd_count got=%0d exp=4", count2); end
    endtask

    task automatic test_byteenable();
        int w; logic [31:0] d;
        bus_xfer(0, 32'd8, 1'b0, 1'b1, 32'h1122_3344, 4'hF, w, d);
        bus_xfer(0, 32'd8, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, w, d);
        bus_xfer(0, 32'd8, 1'b1, 1'b0, 32'd0, 4'h0, w, d);
        vectors++; if (d !== 32'h11BB_33DD) begin fails++; $display("FAIL be_merge got=%h exp=11bb33dd", d); end
        vectors++; if (count2 !== 32'd7) begin fails++; $display("FAIL be_count got=%0d exp=7", count2); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat; logic [31:0] d1, d2;
        pat = 6'd0; d1 = 32'd0; d2 = 32'd0;
        set_req(0, 32'd100, 1'b1, 1'b0, 32'd0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            #1;
            pat[i] = bus2.waitrequest;
            if (i == 2) d1 = bus2.readdata;
            if (i == 5) d2 = bus2.readdata;
            @(posedge clk); #1;
        end
        set_req(0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        vectors++; if (pat !== 6'b011011) begin fails++; $display("FAIL b2b_wait_pattern got=%b exp=011011", pat); end
        vectors++; if (d1 !== 32'd9 || d2 !== 32'd9) begin fails++; $display("FAIL b2b_data got=%h/%h exp=9/9", d1, d2); end
        vectors++; if (count2 !== 32'd9) begin fails++; $display("FAIL b2b_count got=%0d exp=9", count2); end
    endtask

    task automatic test_rw_conflict();
        int w; logic [31:0] d;
        bus_xfer(0, 32'd16, 1'b0, 1'b1, 32'h0000_0055, 4'hF, w, d);
        set_req(0, 32'd16, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF);
        #1;
        vectors++; if (bus2.waitrequest !== 1'b0) begin fails++; $display("FAIL rw_wait got=%b exp=0", bus2.waitrequest); end
        vectors++; if (bus2.readdata !== 32'd0) begin fails++; $display("FAIL rw_rdata got=%h exp=0", bus2.readdata); end
        @(posedge clk); #1;
        set_req(0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        vectors++; if (error2 !== 1'b1) begin fails++; $display("FAIL rw_error got=%b exp=1", error2); end
        vectors++; if (count2 !== 32'd10) begin fails++; $display("FAIL rw_count got=%0d exp=10", count2); end
        bus_xfer(0, 32'd16, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (d !== 32'h0000_0055) begin fails++; $display("FAIL rw_ram_kept got=%h exp=00000055", d); end
        vectors++; if (error2 !== 1'b1) begin fails++; $display("FAIL rw_error_sticky got=%b exp=1", error2); end
        pulse_reset();
        vectors++; if (error2 !== 1'b0 || count2 !== 32'd0) begin fails++; $display("FAIL rw_reset_clear got=%b/%0d exp=0/0", error2, count2); end
    endtask

    task automatic test_misaligned();
        int w; logic [31:0] d;
        bus_xfer(0, 32'd9, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (w !== 2) begin fails++; $display("FAIL mis_waits got=%0d exp=2", w); end
        vectors++; if (d !== 32'd0) begin fails++; $display("FAIL mis_rdata got=%h exp=0", d); end
        vectors++; if (error2 !== 1'b1) begin fails++; $display("FAIL mis_error got=%b exp=1", error2); end
        bus_xfer(0, 32'd10, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, w, d);
        vectors++; if (count2 !== 32'd0) begin fails++; $display("FAIL mis_count got=%0d exp=0", count2); end
        bus_xfer(0, 32'd8, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (d !== 32'h11BB_33DD) begin fails++; $display("FAIL mis_no_write got=%h exp=11bb33dd", d); end
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] d;
        bus_xfer(0, 32'd12, 1'b0, 1'b1, 32'h0000_C0C0, 4'hF, w, d);
        set_req(0, 32'd12, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        vectors++; if (bus2.waitrequest !== 1'b0) begin fails++; $display("FAIL rstmid_wait got=%b exp=0", bus2.waitrequest); end
        @(posedge clk); #1;
        reset = 1'b0;
        set_req(0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        vectors++; if (error2 !== 1'b0 || count2 !== 32'd0) begin fails++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", error2, count2); end
        @(posedge clk); #1;
        bus_xfer(0, 32'd12, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (d !== 32'h0000_C0C0) begin fails++; $display("FAIL rstmid_ram got=%h exp=0000c0c0", d); end
        vectors++; if (count2 !== 32'd1) begin fails++; $display("FAIL rstmid_count got=%0d exp=1", count2); end
    endtask

    task automatic test_addr_change();
        int w; logic [31:0] d;
        bus_xfer(0, 32'd4, 1'b0, 1'b1, 32'h0000_00A4, 4'hF, w, d);
        set_req(0, 32'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        bus2.address = 32'd8;
        #1;
        vectors++; if (bus2.waitrequest !== 1'b1) begin fails++; $display("FAIL chg_wait got=%b exp=1", bus2.waitrequest); end
        @(posedge clk); #1;
        set_req(0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
        vectors++; if (error2 !== 1'b1) begin fails++; $display("FAIL chg_error got=%b exp=1", error2); end
        vectors++; if (count2 !== 32'd2) begin fails++; $display("FAIL chg_count got=%0d exp=2", count2); end
        bus_xfer(0, 32'd4, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (w !== 2 || d !== 32'h0000_00A4) begin fails++; $display("FAIL chg_rd4 got=%0d/%h exp=2/000000a4", w, d); end
        bus_xfer(0, 32'd8, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (d !== 32'h11BB_33DD) begin fails++; $display("FAIL chg_rd8 got=%h exp=11bb33dd", d); end
    endtask

    task automatic test_zero_wait();
        int w; logic [31:0] d;
        bus_xfer(1, 32'd20, 1'b0, 1'b1, 32'h0000_0077, 4'hF, w, d);
        vectors++; if (w !== 0) begin fails++; $display("FAIL zw_write_waits got=%0d exp=0", w); end
        bus_xfer(1, 32'd20, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (w !== 0 || d !== 32'h0000_0077) begin fails++; $display("FAIL zw_read got=%0d/%h exp=0/00000077", w, d); end
        vectors++; if (count0 !== 32'd2 || error0 !== 1'b0) begin fails++; $display("FAIL zw_count got=%0d/%b exp=2/0", count0, error0); end
        bus_xfer(1, 32'd22, 1'b1, 1'b0, 32'd0, 4'hF, w, d);
        vectors++; if (d !== 32'd0 || error0 !== 1'b1 || count0 !== 32'd2) begin fails++; $display("FAIL zw_mis got=%h/%b/%0d exp=0/1/2", d, error0, count0); end
    endtask

    initial begin
        test_reset();
        test_boot_read();
        test_write_read();
        test_byteenable();
        test_back_to_back();
        test_rw_conflict();
        test_misaligned();
        test_reset_mid();
        test_addr_change();
        test_zero_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
